// File: rtl/lfm_gen_pkg.sv
// Shared constants for the LFM phase accumulator: signal types, FSM states and dither LFSR.
package lfm_gen_pkg;

    localparam logic [1:0] TYPE_TONE  = 2'd0;
    localparam logic [1:0] TYPE_UP    = 2'd1;
    localparam logic [1:0] TYPE_DOWN  = 2'd2;
    localparam logic [1:0] TYPE_BIDIR = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfm_phase_core.sv
// Phase/FTW accumulator with mode-dependent chirp update and address truncation.
// Optional address dither is enabled by defining LFM_PHASE_DITHER_EN.
module lfm_phase_core
    import lfm_gen_pkg::*;
#(
    parameter int unsigned PHASE_W = 48,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DFTW_W  = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               load,
    input  logic               step,
    input  logic               second_half,
    input  logic [1:0]         sig_type,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [DFTW_W-1:0]  dftw,
    output logic [ADDR_W-1:0]  rom_addr
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] ftw_q;
    logic [PHASE_W-1:0] ftw_next;
    logic [PHASE_W-1:0] dftw_ext;

    assign dftw_ext = PHASE_W'(dftw);

    always_comb begin
        ftw_next = ftw_q;
        unique case (sig_type)
            TYPE_TONE:  ftw_next = ftw_q;
            TYPE_UP:    ftw_next = ftw_q + dftw_ext;
            TYPE_DOWN:  ftw_next = ftw_q - dftw_ext;
            TYPE_BIDIR: ftw_next = second_half ? (ftw_q - dftw_ext) : (ftw_q + dftw_ext);
            default:    ftw_next = ftw_q;
        endcase
    end

    // Reload wins over step so the last sample of a pulse hands over to a fresh pulse
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            phase_q <= '0;
            ftw_q   <= '0;
        end else if (load) begin
            phase_q <= '0;
            ftw_q   <= f_start;
        end else if (step) begin
            phase_q <= phase_q + ftw_q;
            ftw_q   <= ftw_next;
        end
    end

`ifdef LFM_PHASE_DITHER_EN
    localparam int unsigned DITHER_W = (PHASE_W - ADDR_W < 16) ? (PHASE_W - ADDR_W) : 16;

    logic [15:0]        lfsr_q;
    logic [PHASE_W-1:0] phase_dith;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    assign phase_dith = phase_q + PHASE_W'(lfsr_q[DITHER_W-1:0]);
    assign rom_addr   = phase_dith[PHASE_W-1 -: ADDR_W];
`else
    assign rom_addr = phase_q[PHASE_W-1 -: ADDR_W];
`endif

endmodule

// File: rtl/lfm_phase_accum_gen.sv
// Packet sequencer for the DDS phase accumulator: FSM, pulse/period counters, valid/ready.
// Optional address dither in lfm_phase_core via LFM_PHASE_DITHER_EN.
module lfm_phase_accum_gen
    import lfm_gen_pkg::*;
#(
    parameter int unsigned PHASE_W = 48,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DFTW_W  = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NIMP_W  = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SIGN_START_GEN,
    input  logic [1:0]         SIGNAL_TYPE,
    input  logic [PHASE_W-1:0] F_START,
    input  logic [DFTW_W-1:0]  DFTW,
    input  logic [CNT_W-1:0]   IMP_SAMPLES,
    input  logic [CNT_W-1:0]   PER_SAMPLES,
    input  logic [NIMP_W-1:0]  NUM_OF_IMP,
    input  logic               OUT_REG_READY,
    output logic [ADDR_W-1:0]  ROM_ADDRESS,
    output logic               ADDR_VALID,
    output logic               GATE,
    output logic               BUSY,
    output logic               SIGN_START_CALC,
    output logic               SIGN_STOP_CALC
);

    state_t             state_q;
    logic [1:0]         type_q;
    logic [PHASE_W-1:0] fstart_q;
    logic [DFTW_W-1:0]  dftw_q;
    logic [CNT_W-1:0]   imp_q;
    logic [CNT_W-1:0]   per_q;
    logic [NIMP_W-1:0]  num_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NIMP_W-1:0]  pcnt_q;
    logic               first_q;
    logic [ADDR_W-1:0]  addr_hold_q;

    logic               accept, valid, in_pulse, pulse_end, period_end, pkt_end;
    logic               reload, clr, step, second_half;
    logic [PHASE_W-1:0] f_start_sel;
    logic [ADDR_W-1:0]  core_addr, cur_addr;

    assign in_pulse  = (state_q == ST_PULSE);
    assign valid     = (state_q != ST_IDLE) && OUT_REG_READY;
    assign accept    = (state_q == ST_IDLE) && SIGN_START_GEN && OUT_REG_READY &&
                       (NUM_OF_IMP != '0) && (PER_SAMPLES != '0) && (IMP_SAMPLES != '0);
    assign pulse_end = in_pulse && (cnt_q == imp_q - CNT_W'(1));
    assign pkt_end   = pulse_end && (pcnt_q == num_q - NIMP_W'(1));
    assign period_end = (pulse_end && !(per_q > imp_q)) ||
                        ((state_q == ST_GAP) && (cnt_q == per_q - CNT_W'(1)));

    assign reload      = accept || (valid && period_end && !pkt_end);
    assign clr         = valid && pkt_end;
    assign step        = valid && in_pulse;
    assign second_half = (cnt_q >= (imp_q >> 1));
    // Config is latched on the accept edge, so the core must see the live F_START then
    assign f_start_sel = (state_q == ST_IDLE) ? F_START : fstart_q;

    lfm_phase_core #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .DFTW_W  (DFTW_W)
    ) u_core (
        .CLK         (CLK),
        .RESET       (RESET),
        .clr         (clr),
        .load        (reload),
        .step        (step),
        .second_half (second_half),
        .sig_type    (type_q),
        .f_start     (f_start_sel),
        .dftw        (dftw_q),
        .rom_addr    (core_addr)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            type_q      <= '0;
            fstart_q    <= '0;
            dftw_q      <= '0;
            imp_q       <= '0;
            per_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            pcnt_q      <= '0;
            first_q     <= 1'b0;
            addr_hold_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                state_q     <= ST_PULSE;
                type_q      <= SIGNAL_TYPE;
                fstart_q    <= F_START;
                dftw_q      <= DFTW;
                imp_q       <= (IMP_SAMPLES < PER_SAMPLES) ? IMP_SAMPLES : PER_SAMPLES;
                per_q       <= PER_SAMPLES;
                num_q       <= NUM_OF_IMP;
                cnt_q       <= '0;
                pcnt_q      <= '0;
                first_q     <= 1'b1;
                addr_hold_q <= '0;
            end
        end else if (valid) begin
            first_q     <= 1'b0;
            addr_hold_q <= cur_addr;
            if (pkt_end) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                pcnt_q      <= '0;
                addr_hold_q <= '0;
            end else if (period_end) begin
                state_q <= ST_PULSE;
                cnt_q   <= '0;
                pcnt_q  <= pcnt_q + NIMP_W'(1);
            end else begin
                if (pulse_end) state_q <= ST_GAP;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cur_addr        = in_pulse ? core_addr : '0;
    assign ROM_ADDRESS     = valid ? cur_addr : addr_hold_q;
    assign ADDR_VALID      = valid;
    assign GATE            = in_pulse;
    assign BUSY            = (state_q != ST_IDLE);
    assign SIGN_START_CALC = first_q && valid;
    assign SIGN_STOP_CALC  = valid && pkt_end;

endmodule

// File: tb/tb_lfm_phase_accum_gen.sv
// Scoreboard bench for lfm_phase_accum_gen: a packet-level model fills an expectation queue,
// a negedge monitor pops and compares every valid sample.
module tb_lfm_phase_accum_gen;

    localparam int PHASE_W = 48;
    localparam int ADDR_W  = 12;
    localparam int DFTW_W  = 48;
    localparam int CNT_W   = 32;
    localparam int NIMP_W  = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              gate;
        logic              start;
        logic              stop;
    } exp_t;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               SIGN_START_GEN = 1'b0;
    logic [1:0]         SIGNAL_TYPE = '0;
    logic [PHASE_W-1:0] F_START = '0;
    logic [DFTW_W-1:0]  DFTW = '0;
    logic [CNT_W-1:0]   IMP_SAMPLES = '0;
    logic [CNT_W-1:0]   PER_SAMPLES = '0;
    logic [NIMP_W-1:0]  NUM_OF_IMP = '0;
    logic               OUT_REG_READY = 1'b1;
    logic [ADDR_W-1:0]  ROM_ADDRESS;
    logic               ADDR_VALID, GATE, BUSY, SIGN_START_CALC, SIGN_STOP_CALC;

    int   checks = 0;
    int   failures = 0;
    int   popped = 0;
    exp_t exp_q[$];

    lfm_phase_accum_gen #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .DFTW_W  (DFTW_W),
        .CNT_W   (CNT_W),
        .NIMP_W  (NIMP_W)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SIGN_START_GEN  (SIGN_START_GEN),
        .SIGNAL_TYPE     (SIGNAL_TYPE),
        .F_START         (F_START),
        .DFTW            (DFTW),
        .IMP_SAMPLES     (IMP_SAMPLES),
        .PER_SAMPLES     (PER_SAMPLES),
        .NUM_OF_IMP      (NUM_OF_IMP),
        .OUT_REG_READY   (OUT_REG_READY),
        .ROM_ADDRESS     (ROM_ADDRESS),
        .ADDR_VALID      (ADDR_VALID),
        .GATE            (GATE),
        .BUSY            (BUSY),
        .SIGN_START_CALC (SIGN_START_CALC),
        .SIGN_STOP_CALC  (SIGN_STOP_CALC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 64'({ROM_ADDRESS, ADDR_VALID, GATE, BUSY, SIGN_START_CALC, SIGN_STOP_CALC}),
              64'd0);
    endtask

    // Reference: each period restarts phase 0 / ftw F_START; gap samples carry address 0.
    task automatic build_expect(input logic [1:0] t, input logic [PHASE_W-1:0] fs,
                                input logic [PHASE_W-1:0] d, input int imp, input int per,
                                input int num);
        int eff, len;
        logic [PHASE_W-1:0] ph, fw;
        exp_t e;
        eff = (imp < per) ? imp : per;
        for (int p = 0; p < num; p++) begin
            ph  = '0;
            fw  = fs;
            len = (p == num - 1) ? eff : per;
            for (int k = 0; k < len; k++) begin
                if (k < eff) begin
                    e.addr = ph[PHASE_W-1 -: ADDR_W];
                    e.gate = 1'b1;
                    ph = ph + fw;
                    case (t)
                        2'd1: fw = fw + d;
                        2'd2: fw = fw - d;
                        2'd3: fw = (k < (eff >> 1)) ? fw + d : fw - d;
                        default: fw = fw;
                    endcase
                end else begin
                    e.addr = '0;
                    e.gate = 1'b0;
                end
                e.start = (p == 0) && (k == 0);
                e.stop  = (p == num - 1) && (k == len - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            if (BUSY && !OUT_REG_READY) check("stall_valid", 64'(ADDR_VALID), 64'd0);
            if (ADDR_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample",
                          64'({ROM_ADDRESS, GATE, SIGN_START_CALC, SIGN_STOP_CALC}), 64'(e));
                    popped++;
                end
            end
        end
    end

    task automatic drive_cfg(input logic [1:0] t, input logic [PHASE_W-1:0] fs,
                             input logic [DFTW_W-1:0] d, input int imp, input int per,
                             input int num);
        SIGNAL_TYPE = t;
        F_START     = fs;
        DFTW        = d;
        IMP_SAMPLES = CNT_W'(imp);
        PER_SAMPLES = CNT_W'(per);
        NUM_OF_IMP  = NIMP_W'(num);
    endtask

    // rmode: 0 ready always high, 1 random stalls, 2 three-cycle stall mid-pulse
    task automatic run_packet(input logic [1:0] t, input logic [PHASE_W-1:0] fs,
                              input logic [DFTW_W-1:0] d, input int imp, input int per,
                              input int num, input int rmode);
        int cyc;
        build_expect(t, fs, PHASE_W'(d), imp, per, num);
        drive_cfg(t, fs, d, imp, per, num);
        SIGN_START_GEN = 1'b1;
        OUT_REG_READY  = 1'b1;
        @(posedge CLK); #1;
        check("busy_after_start", 64'(BUSY), 64'd1);
        cyc = 0;
        while (BUSY && cyc < 5000) begin
            case (rmode)
                1: OUT_REG_READY = ($urandom_range(0, 3) != 0);
                2: OUT_REG_READY = !(cyc >= 3 && cyc < 6);
                default: OUT_REG_READY = 1'b1;
            endcase
            // Junk on start and config while busy must not disturb the packet
            SIGN_START_GEN = 1'($urandom);
            SIGNAL_TYPE    = 2'($urandom);
            F_START        = {16'($urandom), $urandom};
            DFTW           = {16'($urandom), $urandom};
            IMP_SAMPLES    = CNT_W'($urandom_range(1, 9));
            PER_SAMPLES    = CNT_W'($urandom_range(1, 9));
            NUM_OF_IMP     = NIMP_W'($urandom_range(1, 3));
            @(posedge CLK); #1;
            cyc++;
        end
        SIGN_START_GEN = 1'b0;
        OUT_REG_READY  = 1'b1;
        check("packet_done_in_time", 64'(BUSY), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge CLK);
        check_idle("idle_after_packet");
        @(posedge CLK); #1;
    endtask

    initial begin
        int base, cyc;
        logic [1:0] t;
        int imp, per;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_idle("reset_state");
        @(posedge CLK); #1;

        run_packet(2'd0, 48'h1 << 36, '0, 8, 8, 1, 0);            // tone
        run_packet(2'd1, '0, 48'h1 << 36, 6, 6, 1, 0);            // up chirp
        run_packet(2'd3, '0, 48'h1 << 36, 6, 6, 2, 0);            // bidir, two pulses
        run_packet(2'd2, 48'h40 << 36, 48'h1 << 36, 5, 5, 1, 0);  // down chirp
        run_packet(2'd0, 48'h1 << 36, '0, 3, 5, 2, 0);            // pulse train with gap
        run_packet(2'd1, '0, 48'h1 << 36, 8, 8, 1, 2);            // mid-pulse stall

        // Starts with a zero config field are ignored
        for (int z = 0; z < 3; z++) begin
            drive_cfg(2'd0, 48'h1 << 36, '0, (z == 0) ? 0 : 4, (z == 1) ? 0 : 4,
                      (z == 2) ? 0 : 1);
            SIGN_START_GEN = 1'b1;
            repeat (3) begin
                @(negedge CLK);
                check("zero_cfg_busy", 64'({BUSY, ADDR_VALID}), 64'd0);
            end
            @(posedge CLK); #1;
            SIGN_START_GEN = 1'b0;
        end

        // Reset in the middle of a packet, then a clean rerun
        build_expect(2'd0, 48'h1 << 36, '0, 8, 8, 1);
        drive_cfg(2'd0, 48'h1 << 36, '0, 8, 8, 1);
        base = popped;
        SIGN_START_GEN = 1'b1;
        @(posedge CLK); #1;
        SIGN_START_GEN = 1'b0;
        cyc = 0;
        while (popped < base + 4 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("reached_sample4", 64'(popped - base), 64'd4);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check_idle("idle_after_reset");
        @(posedge CLK); #1;
        run_packet(2'd0, 48'h1 << 36, '0, 8, 8, 1, 0);

        // Randomised packets with random stalls
        for (int r = 0; r < 25; r++) begin
            t   = 2'($urandom);
            imp = $urandom_range(1, 12);
            per = imp + $urandom_range(0, 5);
            run_packet(t, {16'($urandom), $urandom}, 48'({8'($urandom), $urandom}),
                       imp, per, $urandom_range(1, 4), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
